mul4_vec_scorer: RTL and testbench
==================================

// Module: mul4_vec_scorer
// PURPOSE
//  Downstream fitness stage for the bit-sliced 2x2-bit vector multiplier individuals.
//  - Consumes each candidate's operand planes (a1,a0,b1,b0) and result planes (y3..y0).
//  - Computes the golden product per lane and counts matching result bits.
//  - Accumulates the count over NUM_VECS vectors and reports one fitness score per evaluation.
// PARAMETERS
//  LANES     16  bit-sliced lanes per plane (width of every operand/result plane)
//  NUM_VECS  16  vectors accepted per evaluation
//  SCORE_W   $clog2(NUM_VECS*LANES*4+1)  score width (max score 4*LANES*NUM_VECS)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  start        in   1        pulse: clear accumulator, begin a new evaluation
//  in_valid     in   1        operand/result planes valid
//  in_ready     out  1        stage accepts a vector this cycle
//  a1,a0,b1,b0  in   LANES    operand bit planes (a={a1,a0}, b={b1,b0} per lane)
//  y3,y2,y1,y0  in   LANES    candidate product bit planes
//  score        out  SCORE_W  matching-bit count, valid while score_valid
//  score_valid  out  1        high in DONE until next start/rst
//  perfect      out  1        score_valid && score==4*LANES*NUM_VECS
//  busy         out  1        state != IDLE && state != DONE
// BEHAVIOUR
//  - Reset: state=IDLE; score=0, score_valid=0, perfect=0, busy=0, in_ready=0; pipeline valids and counters cleared.
//  - FSM IDLE->RUN on start.
//  - RUN: in_ready=1 while accepted<NUM_VECS. Transfer = in_valid&&in_ready. Gaps in in_valid are legal.
//  - RUN->DRAIN in the cycle after the NUM_VECS-th transfer (in_ready low from then).
//  - DRAIN->DONE once both pipeline stages are empty. DONE holds score until start.
//  - Golden, per lane:
//    e3=a1&a0&b1&b0; e2=a1&b1&~(a0&b0); e1=(a1&b0)^(a0&b1); e0=a0&b0.
//  - Stage 1 (registered): m = ~({y3,y2,y1,y0}^{e3,e2,e1,e0}), 4*LANES match bits.
//  - Stage 2 (registered): acc += popcount(m). The accumulator never wraps: SCORE_W covers the maximum.
//  - Latency: score_valid rises exactly 3 cycles after the last transfer (S1, S2, DONE register).
//  - start in RUN/DRAIN/DONE: restart. In-flight stages flushed, acc=0, accepted=0, score_valid=0, state=RUN next cycle.
//  - start and in_valid in the same cycle: start wins, no transfer that cycle.
//  - start in IDLE with in_valid high: vector is not accepted; first transfer possible the next cycle.
//  - rst mid-evaluation: immediate return to reset state; partial score discarded.
//  - Inputs are ignored when in_ready=0; X on ignored planes must not reach acc.
// CONFIGURATION
//  MUL4_BITERR_EN defined:
//    - Adds output err_plane[4][SCORE_W-2..0]: per result plane (y3..y0), count of mismatching lane bits.
//    - Accumulated, cleared and flushed exactly like acc. Valid with score_valid.
//    - Invariant: sum(err_plane)+score == 4*LANES*NUM_VECS.
//  Not defined: port and counters absent; score behaviour identical.
// STRUCTURE
//  Package mul4_score_pkg:
//    - state_e enum {IDLE,RUN,DRAIN,DONE}
//    - function golden_planes(a1,a0,b1,b0) returning the 4 expected planes
//    - localparam MAX_SCORE function of LANES/NUM_VECS
//  Sub-module mul4_popcount (combinational, parameterised width, adder tree) used by stage 2.
//  Top: FSM, transfer counter, 2-stage pipeline, accumulator.
// TESTING
//  1 Correct planes: start, 16 vectors with y=golden(random a,b)
//    -> score=1024, perfect=1, score_valid 3 cycles after last transfer.
//  2 a1=a0=b1=b0=16'hFFFF, y*=0, 16 vectors
//    -> per lane exp=4'b1001, 2 bits match -> score=512, perfect=0.
//  3 Backpressure: in_valid toggled 1-0-1 over 32 cycles, correct planes
//    -> in_ready drops after 16th transfer, score=1024, no extra vectors counted.
//  4 start asserted after 7 transfers (all correct), then 16 vectors with y*=0, a=b=0xFFFF
//    -> score=512, earlier partial sum discarded.
//  5 rst asserted in DRAIN -> next cycle all outputs 0, state IDLE; fresh start then scores 1024 normally.
//  6 MUL4_BITERR_EN, only y1 inverted vs golden
//    -> err_plane[1]=256, others 0, score=768.

Source files
------------

// File: rtl/mul4_score_pkg.sv
// Shared types and constants for the mul4 vector scorer: FSM states, sizing and the golden
// bit-sliced 2x2-bit product used as the reference for each candidate's result planes.
package mul4_score_pkg;

  localparam int LANES     = 16;
  localparam int NUM_VECS  = 16;
  localparam int MAX_SCORE = 4 * LANES * NUM_VECS;
  localparam int SCORE_W   = $clog2(MAX_SCORE + 1);
  localparam int ERR_W     = SCORE_W - 1;
  localparam int CNT_W     = $clog2(NUM_VECS + 1);
  localparam int POP_W     = $clog2(4 * LANES + 1);
  localparam int PLANE_W   = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Expected product planes {e3,e2,e1,e0}; e2 drops a1&b1 when the 3*3 carry lands in e3.
  function automatic logic [4*LANES-1:0] golden_planes(
    input logic [LANES-1:0] a1,
    input logic [LANES-1:0] a0,
    input logic [LANES-1:0] b1,
    input logic [LANES-1:0] b0
  );
    logic [LANES-1:0] e3;
    logic [LANES-1:0] e2;
    logic [LANES-1:0] e1;
    logic [LANES-1:0] e0;
    e3 = a1 & a0 & b1 & b0;
    e2 = a1 & b1 & ~(a0 & b0);
    e1 = (a1 & b0) ^ (a0 & b1);
    e0 = a0 & b0;
    return {e3, e2, e1, e0};
  endfunction

endpackage

// File: rtl/mul4_popcount.sv
// Combinational population count over W bits, built as a balanced binary adder tree
// (leaves padded with zeros up to the next power of two).
module mul4_popcount #(
  parameter int W = 64
) (
  input  logic [W-1:0]             bits_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int OW = $clog2(W + 1);
  localparam int LV = (W > 1) ? $clog2(W) : 0;
  localparam int P  = 1 << LV;

  // Heap-ordered tree: node i sums children 2i+1 and 2i+2, leaves start at P-1.
  always_comb begin
    logic [OW-1:0] tree [2*P-1];
    tree = '{default: '0};
    for (int i = 0; i < W; i++) begin
      tree[P-1+i] = OW'(bits_i[i]);
    end
    for (int i = P - 2; i >= 0; i--) begin
      tree[i] = tree[2*i+1] + tree[2*i+2];
    end
    cnt_o = tree[0];
  end

endmodule

// File: rtl/mul4_vec_scorer.sv
// Fitness scorer for bit-sliced 2x2-bit multiplier candidates: match planes, popcount, accumulate.
// Optional macro MUL4_BITERR_EN adds per-result-plane mismatch counters on err_plane_o.
module mul4_vec_scorer
  import mul4_score_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [LANES-1:0]   a1_i,
  input  logic [LANES-1:0]   a0_i,
  input  logic [LANES-1:0]   b1_i,
  input  logic [LANES-1:0]   b0_i,
  input  logic [LANES-1:0]   y3_i,
  input  logic [LANES-1:0]   y2_i,
  input  logic [LANES-1:0]   y1_i,
  input  logic [LANES-1:0]   y0_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               score_valid_o,
  output logic               perfect_o,
  output logic               busy_o
`ifdef MUL4_BITERR_EN
  ,output logic [ERR_W-1:0]  err_plane_o [4]
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic [4*LANES-1:0] m_q, m_d;
  logic               s1_vld_q, s1_vld_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic               in_ready_q, in_ready_d;
  logic               score_valid_q, score_valid_d;
  logic               perfect_q, perfect_d;
  logic               busy_q, busy_d;
  logic [POP_W-1:0]   pop;
  logic               xfer;

  // start has priority over a coincident vector
  assign xfer = in_valid_i && in_ready_q && !start_i;

  mul4_popcount #(.W(4 * LANES)) u_pop (
    .bits_i (m_q),
    .cnt_o  (pop)
  );

  // FSM next state, stage-1 capture and accumulator update
  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    s1_vld_d   = 1'b0;
    m_d        = '0;
    acc_d      = acc_q;
    if (start_i) begin
      state_d    = RUN;
      accepted_d = '0;
      acc_d      = '0;
    end else begin
      if (xfer) begin
        s1_vld_d   = 1'b1;
        m_d        = ~({y3_i, y2_i, y1_i, y0_i} ^ golden_planes(a1_i, a0_i, b1_i, b0_i));
        accepted_d = accepted_q + CNT_W'(1);
      end else begin
        accepted_d = accepted_q;
      end
      if (s1_vld_q) begin
        acc_d = acc_q + SCORE_W'(pop);
      end else begin
        acc_d = acc_q;
      end
      case (state_q)
        IDLE:  state_d = IDLE;
        RUN: begin
          if (accepted_d == CNT_W'(NUM_VECS)) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end
        // Stage 2 result lands the cycle after stage 1 empties, so only s1 needs watching.
        DRAIN: begin
          if (!s1_vld_q) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    in_ready_d    = (state_d == RUN) && (accepted_d < CNT_W'(NUM_VECS));
    score_valid_d = (state_d == DONE);
    perfect_d     = (state_d == DONE) && (acc_d == SCORE_W'(MAX_SCORE));
    busy_d        = (state_d == RUN) || (state_d == DRAIN);
  end

  // State, pipeline and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      accepted_q    <= '0;
      m_q           <= '0;
      s1_vld_q      <= 1'b0;
      acc_q         <= '0;
      in_ready_q    <= 1'b0;
      score_valid_q <= 1'b0;
      perfect_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      accepted_q    <= accepted_d;
      m_q           <= m_d;
      s1_vld_q      <= s1_vld_d;
      acc_q         <= acc_d;
      in_ready_q    <= in_ready_d;
      score_valid_q <= score_valid_d;
      perfect_q     <= perfect_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign score_o       = acc_q;
  assign score_valid_o = score_valid_q;
  assign perfect_o     = perfect_q;
  assign busy_o        = busy_q;

`ifdef MUL4_BITERR_EN
  logic [PLANE_W-1:0] plane_miss [4];
  logic [ERR_W-1:0]   err_q [4];
  logic [ERR_W-1:0]   err_d [4];

  for (genvar k = 0; k < 4; k++) begin : g_plane
    mul4_popcount #(.W(LANES)) u_pc (
      .bits_i (~m_q[k*LANES +: LANES]),
      .cnt_o  (plane_miss[k])
    );
  end

  // Per-plane mismatch accumulators track acc exactly (clear, flush, hold)
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      err_d[k] = err_q[k];
      if (start_i) begin
        err_d[k] = '0;
      end else if (s1_vld_q) begin
        err_d[k] = err_q[k] + ERR_W'(plane_miss[k]);
      end else begin
        err_d[k] = err_q[k];
      end
    end
  end

  // Per-plane mismatch registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= '{default: '0};
    end else begin
      err_q <= err_d;
    end
  end

  assign err_plane_o = err_q;
`endif

endmodule

// File: tb/tb_mul4_vec_scorer.sv
// Scoreboard bench for mul4_vec_scorer: directed evaluations push expected scores, a negedge
// monitor pops and compares on each score_valid rise. Define MUL4_BITERR_EN for the err test.
module tb_mul4_vec_scorer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic [10:0] score;
  logic        score_valid, perfect, busy;
`ifdef MUL4_BITERR_EN
  logic [9:0]  err_plane [4];
`endif

  typedef struct {
    int score;
    int perfect;
    int e3, e2, e1, e0;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_xfer = 0;
  int   xfer_cnt = 0;
  logic sv_prev = 1'b0;

  always #5 clk = ~clk;

  mul4_vec_scorer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a1_i(a1), .a0_i(a0), .b1_i(b1), .b0_i(b0),
    .y3_i(y3), .y2_i(y2), .y1_i(y1), .y0_i(y0),
    .score_o(score), .score_valid_o(score_valid), .perfect_o(perfect), .busy_o(busy)
`ifdef MUL4_BITERR_EN
    , .err_plane_o(err_plane)
`endif
  );

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Independent reference: per-lane integer multiply, split into bit planes.
  function automatic logic [63:0] prod_planes(input logic [15:0] pa1, pa0, pb1, pb0);
    logic [15:0] p3, p2, p1, p0;
    int av, bv;
    logic [3:0] p;
    for (int l = 0; l < 16; l++) begin
      av = int'({pa1[l], pa0[l]});
      bv = int'({pb1[l], pb0[l]});
      p = 4'(av * bv);
      p3[l] = p[3]; p2[l] = p[2]; p1[l] = p[1]; p0[l] = p[0];
    end
    return {p3, p2, p1, p0};
  endfunction

  task automatic set_correct();
    a1 = 16'($urandom); a0 = 16'($urandom); b1 = 16'($urandom); b0 = 16'($urandom);
    {y3, y2, y1, y0} = prod_planes(a1, a0, b1, b0);
  endtask

  task automatic set_ones_zero();
    a1 = 16'hFFFF; a0 = 16'hFFFF; b1 = 16'hFFFF; b0 = 16'hFFFF;
    {y3, y2, y1, y0} = 64'h0;
  endtask

  task automatic send();
    bit got = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("send_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    xfer_cnt = 0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (score_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic push(input int s, input int pf, input int e3, input int e2, input int e1, input int e0);
    exp_t e;
    e.score = s; e.perfect = pf; e.e3 = e3; e.e2 = e2; e.e1 = e1; e.e0 = e0;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tracks transfers and checks each new score against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (in_valid && in_ready && !start && !rst) begin
      last_xfer = cyc;
      xfer_cnt++;
    end
    if (score_valid && !sv_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_score", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("score", int'(score), e.score);
        check("perfect", int'(perfect), e.perfect);
        check("latency", cyc - last_xfer, 3);
`ifdef MUL4_BITERR_EN
        check("err3", int'(err_plane[3]), e.e3);
        check("err2", int'(err_plane[2]), e.e2);
        check("err1", int'(err_plane[1]), e.e1);
        check("err0", int'(err_plane[0]), e.e0);
`endif
      end
    end
    sv_prev = score_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_ones_zero();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_score", int'(score), 0);
    check("rst_score_valid", int'(score_valid), 0);
    check("rst_perfect", int'(perfect), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;

    // 1: all-correct planes
    push(1024, 1, 0, 0, 0, 0);
    pulse_start();
    for (int v = 0; v < 16; v++) begin set_correct(); send(); end
    wait_done();

    // 2: a=b=3 on every lane, y=0 -> 2 of 4 bits match per lane
    push(512, 0, 256, 0, 0, 256);
    pulse_start();
    for (int v = 0; v < 16; v++) begin set_ones_zero(); send(); end
    wait_done();

    // 3: in_valid toggling, then wrong planes offered while in_ready is low
    push(1024, 1, 0, 0, 0, 0);
    pulse_start();
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 0) begin set_correct(); in_valid = 1'b1; end
      else begin in_valid = 1'b0; end
      @(posedge clk); #1;
    end
    set_ones_zero();
    in_valid = 1'b1;
    @(negedge clk);
    check("in_ready_after_16", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("xfer_count", xfer_cnt, 16);
    wait_done();

    // 4: restart after 7 transfers; correct vector offered in the start cycle is dropped
    push(512, 0, 256, 0, 0, 256);
    pulse_start();
    for (int v = 0; v < 7; v++) begin set_correct(); send(); end
    set_correct();
    in_valid = 1'b1;
    pulse_start();
    in_valid = 1'b0;
    for (int v = 0; v < 16; v++) begin set_ones_zero(); send(); end
    wait_done();

    // 5: reset while draining, then a fresh evaluation
    pulse_start();
    for (int v = 0; v < 16; v++) begin set_correct(); send(); end
    check("drain_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst2_score", int'(score), 0);
    check("rst2_score_valid", int'(score_valid), 0);
    check("rst2_perfect", int'(perfect), 0);
    check("rst2_busy", int'(busy), 0);
    check("rst2_in_ready", int'(in_ready), 0);
    repeat (4) @(negedge clk);
    check("rst2_no_late_valid", int'(score_valid), 0);
    @(posedge clk); #1;
    push(1024, 1, 0, 0, 0, 0);
    pulse_start();
    for (int v = 0; v < 16; v++) begin set_correct(); send(); end
    wait_done();

`ifdef MUL4_BITERR_EN
    // 6: only y1 wrong on every lane
    push(768, 0, 0, 0, 256, 0);
    pulse_start();
    for (int v = 0; v < 16; v++) begin set_correct(); y1 = ~y1; send(); end
    wait_done();
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
